// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline controller: stage indices, vector
// width, FSM encodings and small mask helpers.
package pipeline_ctrl_pkg;

    // Stage bit positions inside the stall/flush vectors
    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    localparam int STALL_W = 6;

    typedef logic [STALL_W-1:0] stage_vec_t;

    // Controller FSM encodings
    localparam logic [1:0] CTRL_IDLE  = 2'd0;
    localparam logic [1:0] CTRL_WAIT  = 2'd1;
    localparam logic [1:0] CTRL_FLUSH = 2'd2;

    // Every stage that keeps its contents while the redirect is prepared
    localparam stage_vec_t STALL_ALL = 6'b011111;

    // Stages cleared while the redirected PC is refetched
    localparam stage_vec_t FLUSH_VEC = 6'b011110;

    // Freeze every stage from PC up to and including stage k
    function automatic stage_vec_t stall_mask(input logic [2:0] k);
        stage_vec_t m;
        m = '0;
        for (int i = 0; i < STALL_W; i++) begin
            m[i] = (i <= int'(k));
        end
        return m;
    endfunction

    // Bubble inserted into the stage just downstream of stage k
    function automatic stage_vec_t bubble_mask(input logic [2:0] k);
        stage_vec_t m;
        m = '0;
        for (int i = 0; i < STALL_W; i++) begin
            m[i] = (i == int'(k) + 1);
        end
        return m;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the
// destination of a load currently in EX, whose data is not forwardable yet.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       id_ren1_i,
    input  logic       id_ren2_i,
    input  logic [4:0] id_reg1addr_i,
    input  logic [4:0] id_reg2addr_i,
    input  logic       ex_nofwd_i,
    input  logic       ex_wren_i,
    input  logic [4:0] ex_waddr_i,
    output logic       hazard_o
);

    logic rs_match;
    logic rt_match;

    // Compare both ID source operands against the EX load destination; r0 never hazards
    always_comb begin
        rs_match = id_ren1_i && (id_reg1addr_i == ex_waddr_i);
        rt_match = id_ren2_i && (id_reg2addr_i == ex_waddr_i);
        hazard_o = ex_nofwd_i && ex_wren_i && (ex_waddr_i != 5'd0) && (rs_match || rt_match);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central 5-stage pipeline controller: exception redirect sequencing plus
// per-stage stall/flush generation from stall requests and load-use hazards.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int PC_W         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_stallreq_i,
    input  logic            id_stallreq_i,
    input  logic            ex_stallreq_i,
    input  logic            mem_stallreq_i,
    input  logic            mem_busy_i,
    input  logic            id_ren1_i,
    input  logic            id_ren2_i,
    input  logic [4:0]      id_reg1addr_i,
    input  logic [4:0]      id_reg2addr_i,
    input  logic            ex_nofwd_i,
    input  logic            ex_wren_i,
    input  logic [4:0]      ex_waddr_i,
    input  logic            exc_req_i,
    input  logic [PC_W-1:0] exc_pc_i,
    output logic [5:0]      stall_o,
    output logic [5:0]      flush_o,
    output logic            redirect_o,
    output logic [PC_W-1:0] redirect_pc_o,
    output logic            busy_o
);

    // Flush length is meaningful only in 1..7; the counter is 3 bits wide
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    logic [1:0]      state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            first_q, first_d;
    logic [PC_W-1:0] pc_q, pc_d;

    logic            load_use;
    logic [2:0]      stall_src;

    hazard_detect u_hazard (
        .id_ren1_i     (id_ren1_i),
        .id_ren2_i     (id_ren2_i),
        .id_reg1addr_i (id_reg1addr_i),
        .id_reg2addr_i (id_reg2addr_i),
        .ex_nofwd_i    (ex_nofwd_i),
        .ex_wren_i     (ex_wren_i),
        .ex_waddr_i    (ex_waddr_i),
        .hazard_o      (load_use)
    );

    // Next-state logic: exceptions are only accepted from IDLE, and a busy bus defers the flush
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = 1'b0;
        pc_d    = pc_q;
        case (state_q)
            CTRL_IDLE: begin
                if (exc_req_i) begin
                    pc_d = exc_pc_i;
                    if (mem_busy_i) begin
                        state_d = CTRL_WAIT;
                    end else begin
                        state_d = CTRL_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                        first_d = 1'b1;
                    end
                end
            end
            CTRL_WAIT: begin
                if (!mem_busy_i) begin
                    state_d = CTRL_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                    first_d = 1'b1;
                end
            end
            CTRL_FLUSH: begin
                if (cnt_q <= 3'd1) begin
                    state_d = CTRL_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = CTRL_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State, counter, first-flush flag and latched redirect target
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CTRL_IDLE;
            cnt_q   <= 3'd0;
            first_q <= 1'b0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            pc_q    <= pc_d;
        end
    end

    // Highest-priority stall source in IDLE: mem > ex > id/load-use > if (0 = none)
    always_comb begin
        stall_src = 3'd0;
        if (mem_stallreq_i) begin
            stall_src = 3'(STG_MEM);
        end else if (ex_stallreq_i) begin
            stall_src = 3'(STG_EX);
        end else if (id_stallreq_i || load_use) begin
            stall_src = 3'(STG_ID);
        end else if (if_stallreq_i) begin
            stall_src = 3'(STG_IF);
        end
    end

    // Output vectors: flush/wait states override requests; exception acceptance freezes everything
    always_comb begin
        stall_o    = '0;
        flush_o    = '0;
        redirect_o = 1'b0;
        case (state_q)
            CTRL_FLUSH: begin
                flush_o    = FLUSH_VEC;
                redirect_o = first_q;
            end
            CTRL_WAIT: begin
                stall_o = STALL_ALL;
            end
            default: begin
                if (exc_req_i) begin
                    stall_o = STALL_ALL;
                end else if (stall_src != 3'd0) begin
                    stall_o = stall_mask(stall_src);
                    flush_o = bubble_mask(stall_src);
                end
            end
        endcase
    end

    assign redirect_pc_o = pc_q;
    assign busy_o        = (state_q != CTRL_IDLE);

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central pipeline controller for the 5-stage core (IF, ID, EX, MEM, WB). Produces per-stage stall and flush enables from three sources, in priority order: exception redirects from MEM, stall requests from the stages, and load-use hazards between ID and EX. Drives the `*_stall_i` / `*_flush_i` inputs of every stage register bank, including the decoder's `id_stall_i` / `id_flush_i`, and supplies the PC redirect for exceptions.

Parameters:
- FLUSH_CYCLES, 1, number of cycles the flush vector stays asserted after an exception is taken (1..7).
- PC_W, 32, PC width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- if_stallreq_i  in  1  IF stage stall request (icache miss).
- id_stallreq_i  in  1  ID stage stall request.
- ex_stallreq_i  in  1  EX stage stall request (multi-cycle ALU/MDU).
- mem_stallreq_i  in  1  MEM stage stall request (dcache/bus wait).
- mem_busy_i  in  1  data bus transaction outstanding; it cannot be abandoned.
- id_ren1_i  in  1  ID reads rs.
- id_ren2_i  in  1  ID reads rt.
- id_reg1addr_i  in  5  ID rs address.
- id_reg2addr_i  in  5  ID rt address.
- ex_nofwd_i  in  1  EX instruction is a load; its result is not forwardable.
- ex_wren_i  in  1  EX instruction writes the GPR file.
- ex_waddr_i  in  5  EX destination register.
- exc_req_i  in  1  MEM stage reports an exception or eret.
- exc_pc_i  in  PC_W  handler/return address for that exception.
- stall_o  out  6  stall vector; bit 0 = pc, 1 = if, 2 = id, 3 = ex, 4 = mem, 5 = wb.
- flush_o  out  6  flush vector, same bit order.
- redirect_o  out  1  PC redirect valid.
- redirect_pc_o  out  PC_W  redirect target.
- busy_o  out  1  controller is not in IDLE.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - state = IDLE; flush counter = 0.
  - redirect_pc_o = 0; redirect_o = 0; flush_o = 0; stall_o = 0; busy_o = 0.
  - Reset mid-operation abandons WAIT or FLUSH immediately.
- States: IDLE, WAIT, FLUSH.
- IDLE → FLUSH: exc_req_i = 1 and mem_busy_i = 0. Latch exc_pc_i into redirect_pc_o; load the counter with FLUSH_CYCLES.
- IDLE → WAIT: exc_req_i = 1 and mem_busy_i = 1. Latch exc_pc_i.
- WAIT → FLUSH: first cycle with mem_busy_i = 0. Load the counter.
- FLUSH: each cycle, flush_o = 6'b011110 and redirect_o = 1 (redirect_o only in the first FLUSH cycle). Counter decrements; at 1 → IDLE.
- exc_req_i is ignored outside IDLE. exc_pc_i is captured only on the IDLE transition.
- Stall vector, combinational, evaluated only in IDLE with exc_req_i = 0:
  - Stall source k: mem = 4, ex = 3, id = 2, if = 1.
  - Highest active k sets stall_o[k:0] = 1 and flush_o[k+1] = 1 (bubble) unless stall_o[k+1] = 1.
  - mem_stallreq_i gives stall_o = 6'b011111 and flush_o[5] = 1.
- Load-use hazard:
  - Condition: ex_nofwd_i & ex_wren_i & (ex_waddr_i ≠ 0) & ((id_ren1_i & id_reg1addr_i == ex_waddr_i) | (id_ren2_i & id_reg2addr_i == ex_waddr_i)).
  - Treated as an ID-stage source: stall_o = 6'b000111, flush_o[3] = 1.
  - OR'd with id_stallreq_i.
- Exception acceptance cycle (IDLE, exc_req_i = 1): stall_o = 6'b011111, flush_o = 0, so nothing advances while the redirect is prepared.
- WAIT: stall_o = 6'b011111, flush_o = 0.
- FLUSH: stall_o = 0; all stall requests and hazards are ignored.
- Priority: exception > mem > ex > id/load-use > if.
- busy_o = (state ≠ IDLE).
- All state updates occur on the posedge of clk.

Decomposition:
- Shared defines header:
  - stage index constants (STG_PC … STG_WB), stall vector width 6.
  - FSM state encodings (CTRL_IDLE, CTRL_WAIT, CTRL_FLUSH).
- One sub-module, hazard_detect: combinational load-use compare producing a 1-bit hazard.

Test Plan:
- Load-use: ex_nofwd_i = 1, ex_wren_i = 1, ex_waddr_i = 5, id_ren1_i = 1, id_reg1addr_i = 5 → stall_o = 000111, flush_o = 001000. Same with ex_waddr_i = 0 → stall_o = 0, flush_o = 0.
- Stall priority: if_stallreq_i = 1 and ex_stallreq_i = 1 together → stall_o = 001111, flush_o = 010000. mem_stallreq_i alone → stall_o = 011111, flush_o = 100000.
- Exception, bus idle, FLUSH_CYCLES = 1: exc_req_i = 1, exc_pc_i = 0xBFC00380 at cycle N → stall_o = 011111 at N. At N+1: flush_o = 011110, redirect_o = 1, redirect_pc_o = 0xBFC00380. At N+2: IDLE, flush_o = 0.
- Exception, bus busy: exc_req_i with mem_busy_i = 1 for 3 cycles → busy_o = 1 and stall_o = 011111 throughout WAIT. Flush starts the cycle after mem_busy_i falls. A second exc_req_i with a different PC during WAIT does not change redirect_pc_o.
- FLUSH_CYCLES = 3: flush_o held for exactly 3 cycles; redirect_o high in the first only; stall requests asserted during FLUSH → stall_o = 0.
- Reset in FLUSH: rst_n = 0 for one edge mid-flush → next cycle state = IDLE and all outputs 0.
